// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and default width for the serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell computing a - b - c
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borr
);

  assign diff = a ^ b ^ c;
  assign borr = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial A - B - bin controller; SERIAL_SUB_FLAGS_EN adds zero/neg/ovf flags
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
`endif
  output logic             borr_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  sub_state_t       state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br_ff;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bo;
  logic             last_bit;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             msb_bin;
`endif

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (br_ff),
    .diff (cell_d),
    .borr (cell_bo)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == SHIFT);
  end

  // done is registered so it rises together with the updated diff_out/borr_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      br_ff     <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      diff_out  <= '0;
      borr_out  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      msb_bin   <= 1'b0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            br_ff <= bin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          res_sr <= {cell_d, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br_ff  <= cell_bo;
          cnt    <= cnt + CW'(1);
`ifdef SERIAL_SUB_FLAGS_EN
          if (last_bit) msb_bin <= br_ff;
`endif
        end
        DONE: begin
          done     <= 1'b1;
          diff_out <= res_sr;
          borr_out <= br_ff;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_flag <= (res_sr == '0);
          neg_flag  <= res_sr[WIDTH-1];
          ovf_flag  <= msb_bin ^ br_ff;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - self-checking bench for serial_subtractor_ctrl
module tb_serial_subtractor_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             bin = 1'b0;
  logic             ready, busy, done, borr_out;
  logic [WIDTH-1:0] diff_out;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero_flag, neg_flag, ovf_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .bin      (bin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .diff_out (diff_out),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero_flag(zero_flag),
    .neg_flag (neg_flag),
    .ovf_flag (ovf_flag),
`endif
    .borr_out (borr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] exp_diff;
    logic       exp_borr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic bo, output logic ov);
    int full, sa, sb, s;
    full = int'(a) - int'(b) - int'(bi);
    d    = full[7:0];
    bo   = (full < 0);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    s    = sa - sb - int'(bi);
    ov   = (s < -128) || (s > 127);
  endtask

  // Issues one operation from posedge+1 and returns the done latency in cycles
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output int lat, output logic busy1);
    int waitc = 0;
    while (!ready && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    a_in = a; b_in = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); bin = 1'($urandom);
    lat = -1;
    busy1 = 1'b0;
    for (int k = 1; k <= WIDTH + 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy1 = busy;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic bi, input logic [7:0] ed, input logic eb, input int lat);
    logic [7:0] md;
    logic mb, mo;
    check({tag, "_latency"}, 32'(lat), WIDTH + 1);
    check({tag, "_diff"}, 32'(diff_out), 32'(ed));
    check({tag, "_borr"}, 32'(borr_out), 32'(eb));
    model(a, b, bi, md, mb, mo);
`ifdef SERIAL_SUB_FLAGS_EN
    check({tag, "_zero"}, 32'(zero_flag), 32'(md == 8'h00));
    check({tag, "_neg"},  32'(neg_flag),  32'(md[7]));
    check({tag, "_ovf"},  32'(ovf_flag),  32'(mo));
`endif
  endtask

  vec_t vecs[7];

  initial begin
    int lat, pulses;
    logic b1;
    logic [7:0] ra, rb, md;
    logic rbi, mb, mo;

    vecs[0] = '{8'h5A, 8'h1C, 1'b0, 8'h3E, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[5] = '{8'h33, 8'h33, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    #12;
    check("reset_ready", 32'(ready), 1);
    check("reset_busy",  32'(busy), 0);
    check("reset_done",  32'(done), 0);
    check("reset_diff",  32'(diff_out), 0);
    check("reset_borr",  32'(borr_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat, b1);
      check_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
                   vecs[i].exp_diff, vecs[i].exp_borr, lat);
      check($sformatf("vec%0d_busy", i), 32'(b1), 1);
      if (i == 0) begin
        @(posedge clk); #1;
        check("vec0_ready_after", 32'(ready), 1);
        check("vec0_done_one_cycle", 32'(done), 0);
      end
    end

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      model(ra, rb, rbi, md, mb, mo);
      run_op(ra, rb, rbi, lat, b1);
      check_result($sformatf("rand%0d", i), ra, rb, rbi, md, mb, lat);
    end

    // start during SHIFT must be ignored
    a_in = 8'h05; b_in = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; pulses = 0;
    for (int k = 1; k <= WIDTH + 14; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 3) begin
        a_in = 8'hAA; b_in = 8'h11; start = 1'b1;
      end
      if (done) begin
        pulses++;
        if (lat < 0) lat = k;
        if (k == WIDTH + 1) begin
          check("ignore_diff", 32'(diff_out), 32'h02);
          check("ignore_borr", 32'(borr_out), 0);
        end
      end
    end
    check("ignore_latency", 32'(lat), WIDTH + 1);
    check("ignore_pulses", 32'(pulses), 1);

    // async reset mid-operation
    a_in = 8'h40; b_in = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 1);
    check("abort_busy",  32'(busy), 0);
    check("abort_diff",  32'(diff_out), 0);
    check("abort_borr",  32'(borr_out), 0);
    check("abort_done",  32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(ready), 1);
    run_op(8'h07, 8'h02, 1'b0, lat, b1);
    check_result("after_reset", 8'h07, 8'h02, 1'b0, 8'h05, 1'b0, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It reuses one full-subtractor cell over WIDTH cycles to compute A - B - bin, carrying the borrow in a flip-flop between bit-slices. A start/done handshake sequences the operation. It gives the arithmetic unit an area-minimal subtract path in exchange for WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request; sampled only while ready=1.
a_in  input  WIDTH  minuend; captured on accepted start.
b_in  input  WIDTH  subtrahend; captured on accepted start.
bin  input  1  initial borrow-in; captured on accepted start.
ready  output  1  high in IDLE; start accepted only when high.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse; result valid.
diff_out  output  WIDTH  result A - B - bin modulo 2^WIDTH.
borr_out  output  1  final borrow out of the MSB slice.

Behaviour:
- Reset (async assert): state=IDLE; ready=1; busy=0; done=0; diff_out=0; borr_out=0; shift registers, borrow FF and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1:
  - latch a_in→a_sr, b_in→b_sr, bin→br_ff; cnt=0.
  - next state SHIFT.
- SHIFT, one bit per cycle, LSB first:
  - d = a_sr[0]^b_sr[0]^br_ff.
  - bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&br_ff).
  - res_sr shifts right, d entering at MSB; a_sr and b_sr shift right; br_ff<=bo; cnt++.
  - When cnt==WIDTH-1 on this edge, next state is DONE.
- DONE, exactly one cycle:
  - done=1; diff_out<=res_sr; borr_out<=br_ff.
  - next state IDLE.
- Latency: start accepted at edge 0; SHIFT occupies edges 1..WIDTH; done high during the cycle after edge WIDTH+1. Back-to-back throughput is one op per WIDTH+2 cycles.
- diff_out and borr_out hold their value until the next DONE or reset.
- start while busy or in DONE is ignored; there is no queuing.
- Operand inputs are don't-care except on the accepting edge.
- cnt width is $clog2(WIDTH)+1 and never wraps during an operation.
- Reset asserted mid-operation aborts immediately. The in-progress result is discarded and outputs return to their reset values. After rst deasserts, the block is in IDLE and ready.

Optional Feature:
Macro SERIAL_SUB_FLAGS_EN.
- When defined, adds three outputs, all updated only in DONE and all 0 at reset:
  - zero_flag (1): diff result == 0.
  - neg_flag (1): diff result MSB.
  - ovf_flag (1): signed overflow = (borrow into MSB slice) XOR (borrow out of MSB slice). Requires a 1-bit register capturing br_ff before the last SHIFT cycle.
- When undefined, these ports and the extra register do not exist; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
  - localparam DEFAULT_WIDTH = 8.
- One sub-module: full_subtractor (inputs a, b, c; outputs diff, borr), instantiated once as the per-bit cell. The controller owns only registers and the FSM.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x1C, bin=0 → diff_out=0x3E, borr_out=0. done appears exactly 9 cycles after the accepting edge; ready returns next cycle.
2. a=0x10, b=0x20, bin=0 → diff_out=0xF0, borr_out=1.
3. a=0x00, b=0x00, bin=1 → diff_out=0xFF, borr_out=1. Then a=0xFF, b=0xFF, bin=0 → 0x00, borr 0.
4. Start a=0x05, b=0x03. Pulse start with a=0xAA, b=0x11 at SHIFT cycle 3 → second request ignored; result 0x02, borr 0; only one done pulse.
5. Assert rst at SHIFT cycle 4 → outputs 0 and ready=1 within the same cycle (async). After release, a=0x07, b=0x02 → 0x05.
6. With SERIAL_SUB_FLAGS_EN:
   - a=0x80, b=0x01 → 0x7F, ovf=1, neg=0, zero=0.
   - a=0x33, b=0x33 → zero=1, ovf=0.
